cnn_stream_feeder: RTL and testbench

Parametrised multi-channel stream feeder for the CNN accelerator. It replays preloaded word sequences into the IFmap, filter and psum buffer write ports (one channel per buffer) using their write-enable/ready handshake. Per-word gap counts insert idle cycles between writes. Optional loop mode repeats a sequence. It turns hand-timed buffer stimulus into a synthesizable, cycle-exact source for on-chip self-test and for bench reuse.

---
 rtl/cnn_stream_feeder.sv | 119 +++++++++++
 tb/tb_cnn_stream_feeder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/cnn_stream_feeder.sv
// cnn_stream_feeder: replays preloaded word/gap sequences into per-channel buffer write ports.
module cnn_stream_feeder #(
  parameter int DATA_WIDTH = 18,
  parameter int DEPTH      = 32,
  parameter int NUM_CH     = 3,
  parameter int GAP_WIDTH  = 8,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int CH_WIDTH   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         load_en,
  input  logic [CH_WIDTH-1:0]          load_ch,
  input  logic [ADDR_WIDTH-1:0]        load_addr,
  input  logic [DATA_WIDTH-1:0]        load_data,
  input  logic [GAP_WIDTH-1:0]         load_gap,
  input  logic                         cfg_len_wen,
  input  logic [CH_WIDTH-1:0]          cfg_ch,
  input  logic [ADDR_WIDTH:0]          cfg_len,
  input  logic                         loop_mode,
  input  logic                         start,
  input  logic                         abort,
  output logic [NUM_CH*DATA_WIDTH-1:0] out_data,
  output logic [NUM_CH-1:0]            out_wen,
  input  logic [NUM_CH-1:0]            in_ready,
  output logic                         busy,
  output logic                         done
);
  typedef enum logic [1:0] {IDLE, GAP, DRIVE, FIN} st_t;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [CH_WIDTH:0]   NCH_L   = (CH_WIDTH+1)'(NUM_CH);

  logic busy_q, busy_d, done_q, done_d, loop_q, go, ret;
  logic [NUM_CH-1:0] fin;
  logic [ADDR_WIDTH:0] len_q [NUM_CH];
  logic [DATA_WIDTH-1:0] dmem [NUM_CH][DEPTH];
  logic [GAP_WIDTH-1:0] gmem [NUM_CH][DEPTH];

  assign busy = busy_q;
  assign done = done_q;

  // done_q doubles as the cycle that sends every finished channel back to IDLE
  always_comb begin
    go     = start & ~abort & ~busy_q;
    ret    = abort | done_q;
    busy_d = ret ? 1'b0 : (go ? 1'b1 : busy_q);
    done_d = busy_q & (&fin) & ~done_q & ~abort;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      loop_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) len_q[i] <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      loop_q <= go ? loop_mode : loop_q;
      if (cfg_len_wen && !busy_q && ({1'b0, cfg_ch} < NCH_L))
        len_q[cfg_ch] <= (cfg_len > DEPTH_L) ? DEPTH_L : cfg_len;
    end
  end

  // Sequence memory is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (load_en && !busy_q && ({1'b0, load_ch} < NCH_L) && ({1'b0, load_addr} < DEPTH_L)) begin
      dmem[load_ch][load_addr] <= load_data;
      gmem[load_ch][load_addr] <= load_gap;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    st_t st_q, st_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d, nidx;
    logic [GAP_WIDTH-1:0] cnt_q, cnt_d, ngap;
    logic last;
    always_comb begin
      last  = ({1'b0, idx_q} + 1'b1) == len_q[c];
      nidx  = last ? '0 : idx_q + 1'b1;
      ngap  = gmem[c][nidx];
      st_d  = st_q;
      idx_d = idx_q;
      cnt_d = cnt_q;
      if (ret) st_d = IDLE;
      else case (st_q)
        IDLE: if (go) begin
          idx_d = '0;
          cnt_d = gmem[c][0];
          st_d  = (len_q[c] == 0) ? FIN : ((gmem[c][0] != 0) ? GAP : DRIVE);
        end
        GAP: begin
          cnt_d = cnt_q - 1'b1;
          st_d  = (cnt_q == 1) ? DRIVE : GAP;
        end
        DRIVE: if (in_ready[c]) begin
          idx_d = nidx;
          cnt_d = ngap;
          st_d  = (last && !loop_q) ? FIN : ((ngap != 0) ? GAP : DRIVE);
        end
        default: ;
      endcase
    end
    always_ff @(posedge clk) begin
      if (reset) begin
        st_q  <= IDLE;
        idx_q <= '0;
        cnt_q <= '0;
      end else begin
        st_q  <= st_d;
        idx_q <= idx_d;
        cnt_q <= cnt_d;
      end
    end
    assign fin[c]     = st_q == FIN;
    assign out_wen[c] = st_q == DRIVE;
    assign out_data[c*DATA_WIDTH +: DATA_WIDTH] = (st_q == DRIVE) ? dmem[c][idx_q] : '0;
  end
endmodule

// File: tb/tb_cnn_stream_feeder.sv
// tb_cnn_stream_feeder: directed stimulus with a per-channel scoreboard of expected transferred words.
module tb_cnn_stream_feeder;
  logic clk = 0, reset = 1;
  logic load_en = 0, cfg_len_wen = 0, loop_mode = 0, start = 0, abort = 0;
  logic [1:0] load_ch = 0, cfg_ch = 0;
  logic [4:0] load_addr = 0;
  logic [17:0] load_data = 0;
  logic [7:0] load_gap = 0;
  logic [5:0] cfg_len = 0;
  logic [53:0] out_data;
  logic [2:0] out_wen;
  logic [2:0] in_ready = 3'b111;
  logic busy, done;
  int n_cmp = 0, n_bad = 0;
  logic [17:0] exp_q [3][$];

  cnn_stream_feeder dut (
    .clk(clk), .reset(reset), .load_en(load_en), .load_ch(load_ch), .load_addr(load_addr),
    .load_data(load_data), .load_gap(load_gap), .cfg_len_wen(cfg_len_wen), .cfg_ch(cfg_ch),
    .cfg_len(cfg_len), .loop_mode(loop_mode), .start(start), .abort(abort),
    .out_data(out_data), .out_wen(out_wen), .in_ready(in_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // A transfer happens at the coming rising edge when wen and ready are both high
  always @(negedge clk) begin
    if (!reset) for (int c = 0; c < 3; c++) if (out_wen[c] && in_ready[c]) begin
      if (exp_q[c].size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_ch%0d: got unexpected word %0h expected none", c, out_data[c*18 +: 18]);
      end else chk($sformatf("sb_ch%0d", c), 32'(out_data[c*18 +: 18]), 32'(exp_q[c].pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int ch, input int addr, input int data, input int gap);
    load_en = 1; load_ch = 2'(ch); load_addr = 5'(addr); load_data = 18'(data); load_gap = 8'(gap);
    tick();
    load_en = 0;
  endtask

  task automatic setlen(input int ch, input int len);
    cfg_len_wen = 1; cfg_ch = 2'(ch); cfg_len = 6'(len);
    tick();
    cfg_len_wen = 0;
  endtask

  task automatic lens(input int l0, input int l1, input int l2);
    setlen(0, l0); setlen(1, l1); setlen(2, l2);
  endtask

  task automatic go();
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic run_pat(input string name, input int n, input int ch, input logic [15:0] wp,
                         input logic [15:0] dp, input logic [15:0] bp);
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s_wen_k%0d", name, k), 32'(out_wen[ch]), 32'(wp[k]));
      chk($sformatf("%s_done_k%0d", name, k), 32'(done), 32'(dp[k]));
      chk($sformatf("%s_busy_k%0d", name, k), 32'(busy), 32'(bp[k]));
      tick();
    end
  endtask

  task automatic wait_done(input string name);
    logic seen = 0;
    for (int i = 0; i < 80 && !seen; i++) begin
      tick();
      if (done) seen = 1;
    end
    chk({name, "_done_seen"}, 32'(seen), 1);
    tick();
    chk({name, "_busy_low"}, 32'(busy), 0);
  endtask

  task automatic sb_empty(input string name);
    chk({name, "_sb_empty"}, exp_q[0].size() + exp_q[1].size() + exp_q[2].size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    tick(); tick();
    chk("rst_wen", 32'(out_wen), 0);
    chk("rst_data", 32'(out_data[31:0]) | 32'(out_data[53:32]), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    reset = 0;

    // back-to-back words on ch0
    load(0, 0, 1, 0); load(0, 1, 2, 0); load(0, 2, 3, 0);
    lens(3, 0, 0);
    exp_q[0].push_back(1); exp_q[0].push_back(2); exp_q[0].push_back(3);
    go();
    chk("t1_first_data", 32'(out_data[17:0]), 1);
    chk("t1_other_wen", 32'(out_wen[2:1]), 0);
    run_pat("t1", 6, 0, 16'h0007, 16'h0010, 16'h001F);
    sb_empty("t1");

    // idle gaps on ch1
    load(1, 0, 'h11, 2); load(1, 1, 'h22, 5);
    lens(0, 2, 0);
    exp_q[1].push_back('h11); exp_q[1].push_back('h22);
    go();
    run_pat("t2", 12, 1, 16'h0104, 16'h0400, 16'h07FF);
    sb_empty("t2");

    // ready stall on ch2
    load(2, 0, 'h3FFFF, 0); load(2, 1, 'h155, 0);
    lens(0, 0, 2);
    exp_q[2].push_back('h3FFFF); exp_q[2].push_back('h155);
    in_ready[2] = 0;
    go();
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("t3_hold_wen_k%0d", k), 32'(out_wen[2]), 1);
      chk($sformatf("t3_hold_data_k%0d", k), 32'(out_data[53:36]), 'h3FFFF);
      tick();
    end
    in_ready[2] = 1;
    tick();
    chk("t3_second_data", 32'(out_data[53:36]), 'h155);
    wait_done("t3");
    sb_empty("t3");

    // all lengths zero
    lens(0, 0, 0);
    go();
    chk("t4_wen_all", 32'(out_wen), 0);
    run_pat("t4", 3, 0, 16'h0000, 16'h0002, 16'h0003);

    // loop mode then abort
    load(0, 0, 'hA, 0); load(0, 1, 'hB, 0);
    lens(2, 0, 0);
    for (int i = 0; i < 7; i++) exp_q[0].push_back((i % 2 == 0) ? 18'hA : 18'hB);
    loop_mode = 1;
    go();
    loop_mode = 0;
    for (int k = 0; k < 6; k++) tick();
    abort = 1;
    tick();
    abort = 0;
    chk("t5_abort_wen", 32'(out_wen), 0);
    chk("t5_abort_busy", 32'(busy), 0);
    chk("t5_abort_done", 32'(done), 0);
    tick();
    chk("t5_no_done", 32'(done), 0);
    sb_empty("t5");

    // load while busy is dropped; reset mid-playback
    load(0, 0, 5, 0); load(0, 1, 6, 0); load(0, 2, 7, 0);
    lens(3, 0, 0);
    in_ready[0] = 0;
    go();
    chk("t6_busy", 32'(busy), 1);
    load(0, 1, 'h99, 0);
    reset = 1;
    tick();
    reset = 0;
    chk("t6_rst_wen", 32'(out_wen), 0);
    chk("t6_rst_data", 32'(out_data[31:0]) | 32'(out_data[53:32]), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_done", 32'(done), 0);
    go();
    run_pat("t6z", 3, 0, 16'h0000, 16'h0002, 16'h0003);
    in_ready[0] = 1;
    setlen(0, 3);
    exp_q[0].push_back(5); exp_q[0].push_back(6); exp_q[0].push_back(7);
    go();
    wait_done("t6");
    sb_empty("t6");

    // length saturates to full depth
    for (int i = 0; i < 32; i++) begin
      load(1, i, 'h100 + i, 0);
      exp_q[1].push_back(18'('h100 + i));
    end
    lens(0, 63, 0);
    go();
    wait_done("t7");
    sb_empty("t7");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
